// File: rtl/cmp_pkg.sv
// Shared types for the pipelined branch comparator: branch funct3 encoding,
// the per-group {eq, la, sm} flag triple and its MSB-first merge rule.
package cmp_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_op_e;

    typedef struct packed {
        logic eq;
        logic la;
        logic sm;
    } flag_t;

    // Neutral element of the merge: an "equal" group never changes the outcome.
    localparam flag_t FLAG_PAD = '{eq: 1'b1, la: 1'b0, sm: 1'b0};

    function automatic flag_t flag_merge(input flag_t hi, input flag_t lo);
        flag_t r;
        r.eq = hi.eq & lo.eq;
        r.la = hi.la | (hi.eq & lo.la);
        r.sm = hi.sm | (hi.eq & lo.sm);
        return r;
    endfunction

endpackage

// File: rtl/cmp4.sv
// 4-bit unsigned magnitude comparator producing one {eq, la, sm} flag triple.
module cmp4
    import cmp_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    output flag_t              flags
);

    assign flags = {(a == b), (a > b), (a < b)};

endmodule

// File: rtl/cmp_reduce_tree.sv
// Combinational MSB-first reduction of N_GROUPS flag triples into one triple.
// Group 0 is the least significant; missing groups are padded at the low end.
module cmp_reduce_tree
    import cmp_pkg::*;
#(
    parameter int N_GROUPS = 8
) (
    input  flag_t groups [N_GROUPS],
    output flag_t result
);

    localparam int LEVELS = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int P      = 1 << LEVELS;
    localparam int PAD    = P - N_GROUPS;

    always_comb begin
        flag_t work [P];
        for (int i = 0; i < PAD; i++) begin
            work[i] = FLAG_PAD;
        end
        for (int i = 0; i < N_GROUPS; i++) begin
            work[i + PAD] = groups[i];
        end
        // In-place pairwise merge: slot i takes pair (2i+1 as high, 2i as low).
        for (int w = P / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                work[i] = flag_merge(work[2 * i + 1], work[2 * i]);
            end
        end
        result = work[0];
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined magnitude comparator with RV32I branch decode and flush.
// S1 registers per-group flags; S2 reduces them, applies signedness and decodes taken.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_equal,
    output logic             out_larger,
    output logic             out_smaller,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N_GROUPS = WIDTH / GROUP_W;

    flag_t grp_flags [N_GROUPS];

    for (genvar g = 0; g < N_GROUPS; g++) begin : gen_grp
        cmp4 u_cmp4 (
            .a     (a[g*GROUP_W +: GROUP_W]),
            .b     (b[g*GROUP_W +: GROUP_W]),
            .flags (grp_flags[g])
        );
    end

    logic             s1_valid;
    flag_t            s1_flags [N_GROUPS];
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic [2:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_adv;

    // A beat moves across a boundary on the edge where valid & ready are both high.
    // Ready never looks at the upstream valid; the output stage frees up when it
    // is empty or being consumed, and S1 frees up when empty or draining into S2.
    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~rst & (~s1_valid | s2_adv);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_flags <= grp_flags;
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b[WIDTH-1];
            s1_op    <= op;
            s1_tag   <= in_tag;
        end
    end

    flag_t tree_flags;
    flag_t res_flags;
    logic  signed_op;
    logic  res_taken;
    logic  res_illegal;

    cmp_reduce_tree #(.N_GROUPS(N_GROUPS)) u_tree (
        .groups (s1_flags),
        .result (tree_flags)
    );

    always_comb begin
        res_flags   = tree_flags;
        res_taken   = 1'b0;
        signed_op   = ~(s1_op[2] & s1_op[1]);
        res_illegal = (s1_op[2:1] == 2'b01);
        // Differing signs decide a signed compare on their own.
        if (signed_op && (s1_a_msb != s1_b_msb)) begin
            res_flags.eq = 1'b0;
            res_flags.la = ~s1_a_msb;
            res_flags.sm = s1_a_msb;
        end
        case (s1_op)
            BEQ:       res_taken = res_flags.eq;
            BNE:       res_taken = ~res_flags.eq;
            BLT, BLTU: res_taken = res_flags.sm;
            BGE, BGEU: res_taken = ~res_flags.sm;
            default:   res_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_equal   <= 1'b0;
            out_larger  <= 1'b0;
            out_smaller <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_equal   <= res_flags.eq;
                out_larger  <= res_flags.la;
                out_smaller <= res_flags.sm;
                out_taken   <= res_taken;
                out_illegal <= res_illegal;
                out_tag     <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: a 32-bit instance with a scoreboard queue,
// plus a 40-bit instance for the non-power-of-two group count.
module tb_cmp_pipe;

    localparam int W   = 32;
    localparam int W40 = 40;
    localparam int TW  = 5;
    localparam int RW  = TW + 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b;
    logic [2:0]    op;
    logic [TW-1:0] in_tag, out_tag;
    logic          out_equal, out_larger, out_smaller, out_taken, out_illegal;

    logic           in_valid_40, in_ready_40, out_valid_40, out_ready_40;
    logic [W40-1:0] a_40, b_40;
    logic [2:0]     op_40;
    logic [TW-1:0]  in_tag_40, out_tag_40;
    logic           out_equal_40, out_larger_40, out_smaller_40, out_taken_40, out_illegal_40;

    int            n_vec = 0;
    int            n_err = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_got, mon_exp;
    logic [2:0]    op_tbl [6];

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_equal(out_equal), .out_larger(out_larger), .out_smaller(out_smaller),
        .out_taken(out_taken), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    cmp_pipe #(.WIDTH(W40), .TAG_W(TW)) dut40 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_40), .in_ready(in_ready_40),
        .a(a_40), .b(b_40), .op(op_40), .in_tag(in_tag_40),
        .out_valid(out_valid_40), .out_ready(out_ready_40),
        .out_equal(out_equal_40), .out_larger(out_larger_40), .out_smaller(out_smaller_40),
        .out_taken(out_taken_40), .out_illegal(out_illegal_40), .out_tag(out_tag_40)
    );

    // Golden model: signed compare done by biasing the sign bit, then unsigned compare.
    function automatic logic [RW-1:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                            input logic [2:0] mop, input logic [TW-1:0] mtag,
                                            input int w);
        logic [63:0] sbit, mask;
        logic eq, la, sm, tk, il;
        sbit = 64'd1 << (w - 1);
        mask = (sbit << 1) - 64'd1;
        ma = ma & mask;
        mb = mb & mask;
        if (!(mop[2] && mop[1])) begin
            ma = ma ^ sbit;
            mb = mb ^ sbit;
        end
        eq = (ma == mb);
        la = (ma > mb);
        sm = (ma < mb);
        il = (mop[2:1] == 2'b01);
        case (mop)
            3'b000:         tk = eq;
            3'b001:         tk = !eq;
            3'b100, 3'b110: tk = sm;
            3'b101, 3'b111: tk = !sm;
            default:        tk = 1'b0;
        endcase
        return {eq, la, sm, tk, il, mtag};
    endfunction

    // Scoreboard: every consumed result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {out_equal, out_larger, out_smaller, out_taken, out_illegal, out_tag};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got=%h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL result got={eq,la,sm,tk,il,tag}=%b expected=%b", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic [2:0] dop, input logic [TW-1:0] dtag);
        int t;
        t = 0;
        in_valid = 1'b1;
        a        = da;
        b        = db;
        op       = dop;
        in_tag   = dtag;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout in_ready=%b expected=1", in_ready);
        end else if (!flush) begin
            exp_q.push_back(model(64'(da), 64'(db), dop, dtag, W));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            t++;
            @(posedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout outstanding=%0d expected=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; op = 3'b000; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_equal, out_larger, out_smaller, out_taken, out_illegal, out_tag, in_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b expected=0",
                     {out_valid, out_equal, out_larger, out_smaller, out_taken, out_illegal, out_tag, in_ready});
        end
        n_vec++;
        if ({out_valid_40, out_equal_40, out_larger_40, out_smaller_40, out_taken_40, out_illegal_40, out_tag_40} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_40 got=%b expected=0",
                     {out_valid_40, out_equal_40, out_larger_40, out_smaller_40, out_taken_40, out_illegal_40, out_tag_40});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_ready in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        drive(32'd5, 32'd3, 3'b110, 5'd7);
        idle();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early out_valid=%b expected=0", out_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_larger, out_taken, out_tag} !== {1'b1, 1'b1, 1'b0, 5'd7}) begin
            n_err++;
            $display("FAIL latency_result got={v,la,tk,tag}=%b expected=%b",
                     {out_valid, out_larger, out_taken, out_tag}, {1'b1, 1'b1, 1'b0, 5'd7});
        end
        drain();
    endtask

    task automatic test_signedness();
        drive(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 5'd1);
        drive(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 5'd2);
        drive(32'h8000_0000, 32'h8000_0000, 3'b000, 5'd3);
        drive(32'h0000_0001, 32'hFFFF_FFFF, 3'b101, 5'd4);
        drive(32'h1234_5678, 32'h1234_5678, 3'b001, 5'd5);
        drive(32'h0000_0010, 32'h8000_0000, 3'b010, 5'd6);
        drive(32'h8000_0000, 32'h0000_0010, 3'b011, 5'd8);
        idle();
        drain();
    endtask

    task automatic test_streaming();
        time t0;
        logic [W-1:0] ra, rb;
        t0 = $time;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb[W-1] = ~ra[W-1];
            drive(ra, rb, op_tbl[$urandom_range(0, 5)], 5'(i + 16));
        end
        idle();
        n_vec++;
        if (($time - t0) !== 160) begin
            n_err++;
            $display("FAIL stream_throughput elapsed=%0t expected=160", $time - t0);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [TW+5:0] snap;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    drive($urandom, $urandom, op_tbl[$urandom_range(0, 5)], 5'(i + 1));
                end
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                snap = {out_valid, out_equal, out_larger, out_smaller, out_taken, out_illegal, out_tag};
                for (int i = 0; i < 5; i++) begin
                    n_vec++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                        {out_valid, out_equal, out_larger, out_smaller, out_taken, out_illegal, out_tag} !== snap) begin
                        n_err++;
                        $display("FAIL stall_hold in_ready=%b out=%b expected in_ready=0 out=%b",
                                 in_ready,
                                 {out_valid, out_equal, out_larger, out_smaller, out_taken, out_illegal, out_tag},
                                 snap);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL release_ready in_ready=%b expected=1", in_ready);
                end
            end
        join
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'd100, 32'd200, 3'b100, 5'd20);
        drive(32'd300, 32'd300, 3'b000, 5'd21);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(32'd7, 32'd9, 3'b111, 5'd22);
        flush = 1'b0;
        idle();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_clear cycle=%0d out_valid=%b tag=%0d expected out_valid=0",
                         i, out_valid, out_tag);
            end
        end
        @(posedge clk);
        #1;
        drive(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, 5'd23);
        idle();
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(32'd1, 32'd2, 3'b100, 5'd9);
        drive(32'd3, 32'd3, 3'b000, 5'd10);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid cycle=%0d out_valid=%b expected=0", i, out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_width();
        logic [W40-1:0] wa [3];
        logic [W40-1:0] wb [3];
        logic [2:0]     wop [3];
        logic [RW-1:0]  wexp, wgot;
        int t;
        wa[0] = 40'h80_0000_0000; wb[0] = 40'h7F_FFFF_FFFF; wop[0] = 3'b101;
        wa[1] = 40'h80_0000_0000; wb[1] = 40'h7F_FFFF_FFFF; wop[1] = 3'b010;
        wa[2] = 40'h80_0000_0000; wb[2] = 40'h7F_FFFF_FFFF; wop[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            in_valid_40 = 1'b1;
            a_40        = wa[i];
            b_40        = wb[i];
            op_40       = wop[i];
            in_tag_40   = 5'(i + 11);
            wexp        = model(64'(wa[i]), 64'(wb[i]), wop[i], 5'(i + 11), W40);
            t = 0;
            @(negedge clk);
            while (!in_ready_40 && t < 50) begin
                t++;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            in_valid_40 = 1'b0;
            t = 0;
            @(negedge clk);
            while (!out_valid_40 && t < 20) begin
                t++;
                @(negedge clk);
            end
            wgot = {out_equal_40, out_larger_40, out_smaller_40, out_taken_40, out_illegal_40, out_tag_40};
            n_vec++;
            if (out_valid_40 !== 1'b1 || wgot !== wexp) begin
                n_err++;
                $display("FAIL width40 case=%0d valid=%b got=%b expected=%b", i, out_valid_40, wgot, wexp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        op_tbl[0] = 3'b000; op_tbl[1] = 3'b001; op_tbl[2] = 3'b100;
        op_tbl[3] = 3'b101; op_tbl[4] = 3'b110; op_tbl[5] = 3'b111;
        in_valid_40 = 1'b0; out_ready_40 = 1'b1;
        a_40 = '0; b_40 = '0; op_40 = 3'b000; in_tag_40 = '0;
        test_reset();
        test_signedness();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
